// File: rtl/fifo_read_ctrl.sv
// Read-side pointer and flag controller for a Gray-pointer async-style FIFO.
// Tracks the read pointer, synchronises the writer's pointer and derives flags.
module fifo_read_ctrl #(
  parameter int SIZE        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [SIZE-1:0] wr_ptr_gray,
  output logic [SIZE-1:0] rd_ptr_gray,
  output logic [SIZE-2:0] rd_addr,
  output logic            empty,
  output logic            rd_valid,
  output logic            underflow,
  output logic [SIZE-1:0] rd_count
);

  logic [SIZE-1:0] sync_q [SYNC_STAGES];
  logic [SIZE-1:0] wr_gray_s;
  logic [SIZE-1:0] wr_bin_s;
  logic [SIZE-1:0] rd_bin;
  logic [SIZE-1:0] rd_bin_next;
  logic [SIZE-1:0] rd_gray_next;
  logic            rd_fire;

  function automatic logic [SIZE-1:0] gray2bin(
    input logic [SIZE-1:0] g
  );
    logic [SIZE-1:0] b;
    b[SIZE-1] = g[SIZE-1];
    for (int i = SIZE - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_gray_s = sync_q[SYNC_STAGES-1];
  assign wr_bin_s  = gray2bin(wr_gray_s);

  // Only the registered empty gates reads, so a stale
  // view can delay a read but never over-read.
  assign rd_fire      = rd_en & ~empty;
  assign rd_bin_next  = rd_bin + {{(SIZE-1){1'b0}}, rd_fire};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign rd_addr      = rd_bin[SIZE-2:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bin      <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      rd_valid    <= 1'b0;
      underflow   <= 1'b0;
      rd_count    <= '0;
    end else begin
      rd_bin      <= rd_bin_next;
      rd_ptr_gray <= rd_gray_next;
      empty       <= (rd_gray_next == wr_gray_s);
      rd_valid    <= rd_fire;
      underflow   <= rd_en & empty;
      rd_count    <= wr_bin_s - rd_bin_next;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed self-checking bench for fifo_read_ctrl.
// Each task drives one scenario and checks its outputs inline.
module tb_fifo_read_ctrl;

  logic       clk;
  logic       reset;
  logic       rd_en;
  logic [3:0] wr_ptr_gray;
  logic [3:0] rd_ptr_gray;
  logic [2:0] rd_addr;
  logic       empty;
  logic       rd_valid;
  logic       underflow;
  logic [3:0] rd_count;

  int checks;
  int failures;

  fifo_read_ctrl #(.SIZE(4), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .rd_en       (rd_en),
    .wr_ptr_gray (wr_ptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .rd_addr     (rd_addr),
    .empty       (empty),
    .rd_valid    (rd_valid),
    .underflow   (underflow),
    .rd_count    (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray = 4'b0000;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    wr_ptr_gray = 4'b0000;
    #2;
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_empty got=%b exp=1", empty);
    end
    checks++;
    if (rd_ptr_gray !== 4'b0000 || rd_addr !== 3'd0) begin
      failures++;
      $display("FAIL reset_ptr got=%b/%0d exp=0000/0",
               rd_ptr_gray, rd_addr);
    end
    checks++;
    if (rd_count !== 4'd0 || rd_valid !== 1'b0
        || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_misc cnt=%0d v=%b u=%b exp=0/0/0",
               rd_count, rd_valid, underflow);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    wr_ptr_gray = 4'b0001;
    step();
    step();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL single_lat2 empty=%b exp=1", empty);
    end
    step();
    checks++;
    if (empty !== 1'b0 || rd_count !== 4'd1) begin
      failures++;
      $display("FAIL single_lat3 empty=%b cnt=%0d exp=0/1",
               empty, rd_count);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_ptr_gray !== 4'b0001 || empty !== 1'b1
        || rd_valid !== 1'b1 || rd_addr !== 3'd1) begin
      failures++;
      $display("FAIL single_read g=%b e=%b v=%b a=%0d exp=0001/1/1/1",
               rd_ptr_gray, empty, rd_valid, rd_addr);
    end
    checks++;
    if (rd_count !== 4'd0) begin
      failures++;
      $display("FAIL single_cnt got=%0d exp=0", rd_count);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_vdrop got=%b exp=0", rd_valid);
    end
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
        failures++;
        $display("FAIL uflow_%0d u=%b v=%b exp=1/0",
                 i, underflow, rd_valid);
      end
      checks++;
      if (rd_ptr_gray !== 4'b0001 || rd_addr !== 3'd1) begin
        failures++;
        $display("FAIL uflow_ptr_%0d g=%b a=%0d exp=0001/1",
                 i, rd_ptr_gray, rd_addr);
      end
    end
    rd_en = 1'b0;
    step();
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL uflow_end got=%b exp=0", underflow);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    wr_ptr_gray = 4'b1100;
    step();
    step();
    step();
    checks++;
    if (rd_count !== 4'd8 || empty !== 1'b0) begin
      failures++;
      $display("FAIL drain_fill cnt=%0d e=%b exp=8/0",
               rd_count, empty);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_addr !== 3'(i)) begin
        failures++;
        $display("FAIL drain_addr_%0d got=%0d exp=%0d",
                 i, rd_addr, i);
      end
      step();
      checks++;
      if (rd_valid !== 1'b1 || rd_count !== 4'(7 - i)) begin
        failures++;
        $display("FAIL drain_rd_%0d v=%b cnt=%0d exp=1/%0d",
                 i, rd_valid, rd_count, 7 - i);
      end
    end
    rd_en = 1'b0;
    checks++;
    if (rd_ptr_gray !== 4'b1100 || empty !== 1'b1) begin
      failures++;
      $display("FAIL drain_end g=%b e=%b exp=1100/1",
               rd_ptr_gray, empty);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || rd_ptr_gray !== 4'b1100) begin
      failures++;
      $display("FAIL drain_hold v=%b g=%b exp=0/1100",
               rd_valid, rd_ptr_gray);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] wb;
    logic [3:0] prev;
    int         bad;
    do_reset();
    wb  = 4'd0;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      wb = wb + 4'd1;
      wr_ptr_gray = g(wb);
      step();
      step();
      step();
      prev  = rd_ptr_gray;
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      if ($countones(prev ^ rd_ptr_gray) != 1
          || rd_ptr_gray !== g(wb) || empty !== 1'b1)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL wrap_steps bad=%0d exp=0", bad);
    end
    checks++;
    if (rd_ptr_gray !== 4'b0000) begin
      failures++;
      $display("FAIL wrap_end got=%b exp=0000", rd_ptr_gray);
    end
  endtask

  task automatic test_concurrent();
    wr_ptr_gray = g(4'd1);
    step();
    step();
    step();
    checks++;
    if (empty !== 1'b0 || rd_count !== 4'd1) begin
      failures++;
      $display("FAIL conc_pre e=%b cnt=%0d exp=0/1",
               empty, rd_count);
    end
    rd_en = 1'b1;
    wr_ptr_gray = g(4'd2);
    step();
    rd_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL conc_a e=%b v=%b exp=1/1", empty, rd_valid);
    end
    step();
    checks++;
    if (empty !== 1'b1) begin
      failures++;
      $display("FAIL conc_b e=%b exp=1", empty);
    end
    step();
    checks++;
    if (empty !== 1'b0 || rd_count !== 4'd1) begin
      failures++;
      $display("FAIL conc_c e=%b cnt=%0d exp=0/1",
               empty, rd_count);
    end
    checks++;
    if (rd_addr !== 3'd1) begin
      failures++;
      $display("FAIL conc_addr got=%0d exp=1", rd_addr);
    end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_ptr_gray !== g(4'd2)) begin
      failures++;
      $display("FAIL conc_next v=%b g=%b exp=1/%b",
               rd_valid, rd_ptr_gray, g(4'd2));
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 3; b <= 5; b++) begin
      wr_ptr_gray = g(4'(b));
      step();
    end
    step();
    step();
    checks++;
    if (rd_count !== 4'd3 || empty !== 1'b0) begin
      failures++;
      $display("FAIL mid_pre cnt=%0d e=%b exp=3/0",
               rd_count, empty);
    end
    rd_en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || rd_ptr_gray !== 4'b0000
        || rd_count !== 4'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset e=%b g=%b cnt=%0d v=%b exp=1/0000/0/0",
               empty, rd_ptr_gray, rd_count, rd_valid);
    end
    rd_en = 1'b0;
    wr_ptr_gray = 4'b0000;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_underflow();
    test_full_drain();
    test_wrap();
    test_concurrent();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
